anemo_sample_logger: RTL and testbench

//  Upstream writer for the Nios on-chip RAM (14-bit word address, 32-bit data, byte enables).

---
 rtl/anemo_sample_logger_pkg.sv | 21 ++
 rtl/anemo_sample_logger_if.sv | 30 +++
 rtl/anemo_sample_logger_ptr_ctr.sv | 60 ++++++
 rtl/anemo_sample_logger.sv | 137 +++++++++++++
 tb/tb_anemo_sample_logger.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/anemo_sample_logger_pkg.sv
// Shared types and constants for the anemometer sample logger.
package anemo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int RAM_DATA_W = 32;
  localparam int RAM_BE_W   = 4;

  localparam logic [RAM_BE_W-1:0] BE_LO  = 4'b0011;
  localparam logic [RAM_BE_W-1:0] BE_HI  = 4'b1100;
  localparam logic [RAM_BE_W-1:0] BE_ALL = 4'hF;

  function automatic logic [RAM_BE_W-1:0] half_be(input logic hi);
    return hi ? BE_HI : BE_LO;
  endfunction

endpackage

// File: rtl/anemo_sample_logger_if.sv
// Sample stream plus single-port RAM write bus; master is the logger.
interface anemo_sample_logger_if #(
  parameter int ADDR_W = 14
);
  import anemo_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [15:0]           in_data;
  logic                  mem_grant;
  logic [ADDR_W-1:0]     mem_address;
  logic [RAM_BE_W-1:0]   mem_byteenable;
  logic                  mem_chipselect;
  logic                  mem_write;
  logic [RAM_DATA_W-1:0] mem_writedata;
  logic                  mem_clken;

  modport master (
    input  in_valid, in_data, mem_grant,
    output in_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );

  modport slave (
    output in_valid, in_data, mem_grant,
    input  in_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );

endinterface

// File: rtl/anemo_sample_logger_ptr_ctr.sv
// Wrapping word pointer with optional half-word step and sticky wrap flag.
module anemo_ptr_ctr #(
  parameter int ADDR_W      = 14,
  parameter int DEPTH_WORDS = 10240
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              step,
  input  logic              half_en,
  input  logic              zero,
  output logic [ADDR_W-1:0] ptr,
  output logic              half,
  output logic              wrapped
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH_WORDS - 1);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              half_q, half_d;
  logic              wrapped_q, wrapped_d;

  always_comb begin
    ptr_d     = ptr_q;
    half_d    = half_q;
    wrapped_d = wrapped_q;
    if (zero) begin
      ptr_d     = '0;
      half_d    = 1'b0;
      wrapped_d = 1'b0;
    end else if (step) begin
      if (half_en) half_d = ~half_q;
      // word advances on every step in whole-word mode, else after the upper half
      if (!half_en || half_q) begin
        if (ptr_q == LAST_A) begin
          ptr_d     = '0;
          wrapped_d = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= '0;
      half_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      half_q    <= half_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign ptr     = ptr_q;
  assign half    = half_q;
  assign wrapped = wrapped_q;

endmodule

// File: rtl/anemo_sample_logger.sv
// Packs 16-bit anemometer samples into a circular RAM log; zero-fills the log on request.
//   state | meaning
//   IDLE  | no logging; waits for clear or enable
//   RUN   | accepts samples and writes half-words
//   CLEAR | sweeps the region writing zero words
module anemo_sample_logger
  import anemo_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int BASE_WORD   = 0,
  parameter int DEPTH_WORDS = 10240,
  parameter int SAMPLE_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clear,
  anemo_sample_logger_if.master    bus,
  output logic [ADDR_W-1:0]        wr_ptr,
  output logic                     wr_half,
  output logic                     wrapped,
  output logic                     busy
);

  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH_WORDS - 1);

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [RAM_BE_W-1:0]   be_q, be_d;
  logic [RAM_DATA_W-1:0] data_q, data_d;
  logic                  sweep_done_q, sweep_done_d;
  logic                  clken_q;

  logic ptr_step, ptr_half_en, ptr_zero;
  logic out_free, accept, issue;

  anemo_ptr_ctr #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (ptr_step),
    .half_en (ptr_half_en),
    .zero    (ptr_zero),
    .ptr     (wr_ptr),
    .half    (wr_half),
    .wrapped (wrapped)
  );

  // output register can take a new write when empty or draining this cycle
  assign out_free     = ~pending_q | bus.mem_grant;
  assign bus.in_ready = (state_q == RUN) & enable & out_free;
  assign accept       = bus.in_ready & bus.in_valid;
  assign issue        = (state_q == CLEAR) & ~sweep_done_q & out_free;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q & ~bus.mem_grant;
    addr_d       = addr_q;
    be_d         = be_q;
    data_d       = data_q;
    sweep_done_d = sweep_done_q;
    ptr_step     = 1'b0;
    ptr_half_en  = 1'b1;
    ptr_zero     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clear) begin
          state_d      = CLEAR;
          sweep_done_d = 1'b0;
          ptr_zero     = 1'b1;
        end else if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          pending_d = 1'b1;
          addr_d    = BASE_A + wr_ptr;
          be_d      = half_be(wr_half);
          data_d    = {2{bus.in_data[SAMPLE_W-1:0]}};
          ptr_step  = 1'b1;
        end
        if (!enable && !pending_q) state_d = IDLE;
      end
      CLEAR: begin
        ptr_half_en = 1'b0;
        if (issue) begin
          pending_d = 1'b1;
          addr_d    = BASE_A + wr_ptr;
          be_d      = BE_ALL;
          data_d    = '0;
          ptr_step  = 1'b1;
          if (wr_ptr == LAST_A) sweep_done_d = 1'b1;
        end
        // sweep wraps the shared counter, so re-zero it on the way out
        if (sweep_done_q && out_free) begin
          state_d  = IDLE;
          ptr_zero = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      data_q       <= '0;
      sweep_done_q <= 1'b0;
      clken_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      data_q       <= data_d;
      sweep_done_q <= sweep_done_d;
      clken_q      <= 1'b1;
    end
  end

  assign bus.mem_write      = pending_q;
  assign bus.mem_chipselect = pending_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_byteenable = be_q;
  assign bus.mem_writedata  = data_q;
  assign bus.mem_clken      = clken_q;
  assign busy               = (state_q == CLEAR) | pending_q;

endmodule

// File: tb/tb_anemo_sample_logger.sv
// Scoreboarded bench for anemo_sample_logger with a 4-word region at word 16.
module tb_anemo_sample_logger;
  import anemo_pkg::*;

  localparam int ADDR_W = 14;
  localparam int BASE   = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic [ADDR_W-1:0] wr_ptr;
  logic wr_half, wrapped, busy;

  anemo_sample_logger_if #(.ADDR_W(ADDR_W)) bus ();

  anemo_sample_logger #(
    .ADDR_W(ADDR_W), .BASE_WORD(BASE), .DEPTH_WORDS(DEPTH), .SAMPLE_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .bus(bus),
    .wr_ptr(wr_ptr), .wr_half(wr_half), .wrapped(wrapped), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       data;
  } wr_t;

  wr_t         sb_q[$];
  logic [15:0] tx_q[$];
  wr_t         exp_w, got_w;
  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int m_ptr = 0;
  logic m_half = 1'b0;
  logic m_wrapped = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [3:0]        last_be = '0;

  // write monitor and reference model of the pointer
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mem_write === 1'b1 && bus.mem_grant === 1'b1) begin
        wr_count++;
        got_w = '{addr: bus.mem_address, be: bus.mem_byteenable, data: bus.mem_writedata};
        last_addr = got_w.addr;
        last_be = got_w.be;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected_write: got addr=%0d be=%h data=%h, required no write",
                   got_w.addr, got_w.be, got_w.data);
        end else begin
          exp_w = sb_q.pop_front();
          if (got_w !== exp_w) begin
            n_err++;
            $display("FAIL sb_write: got addr=%0d be=%h data=%h, required addr=%0d be=%h data=%h",
                     got_w.addr, got_w.be, got_w.data, exp_w.addr, exp_w.be, exp_w.data);
          end
        end
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        exp_w.addr = ADDR_W'(BASE + m_ptr);
        exp_w.be   = m_half ? 4'b1100 : 4'b0011;
        exp_w.data = {bus.in_data, bus.in_data};
        sb_q.push_back(exp_w);
        if (m_half) begin
          if (m_ptr == DEPTH - 1) begin
            m_ptr = 0;
            m_wrapped = 1'b1;
          end else begin
            m_ptr = m_ptr + 1;
          end
        end
        m_half = ~m_half;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    sb_q.delete();
    m_ptr = 0;
    m_half = 1'b0;
    m_wrapped = 1'b0;
    reset_n = 1'b1;
    step();
  endtask

  task automatic drain_tx();
    int guard = 0;
    while (tx_q.size() > 0 && guard < 200) begin
      bus.in_valid = 1'b1;
      bus.in_data = tx_q[0];
      @(negedge clk);
      if (bus.in_ready === 1'b1) void'(tx_q.pop_front());
      guard++;
      step();
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (tx_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d samples unaccepted, required 0", tx_q.size());
      tx_q.delete();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 100 && !(sb_q.size() == 0 && bus.mem_write === 1'b0)) begin
      step();
      n++;
    end
    n_cmp++;
    if (n >= 100) begin
      n_err++;
      $display("FAIL idle_timeout: got %0d writes outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_write, bus.mem_chipselect, bus.mem_address, bus.mem_byteenable,
         bus.mem_writedata, bus.mem_clken} !== '0) begin
      n_err++;
      $display("FAIL reset_mem: got addr=%0d be=%h data=%h wr=%b cs=%b clken=%b, required all 0",
               bus.mem_address, bus.mem_byteenable, bus.mem_writedata, bus.mem_write,
               bus.mem_chipselect, bus.mem_clken);
    end
    n_cmp++;
    if ({bus.in_ready, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_ready_busy: got %b%b, required 00", bus.in_ready, busy);
    end
    n_cmp++;
    if ({wr_ptr, wr_half, wrapped} !== '0) begin
      n_err++;
      $display("FAIL reset_ptr: got ptr=%0d half=%b wrapped=%b, required 0 0 0", wr_ptr, wr_half, wrapped);
    end
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_clken !== 1'b0) begin
      n_err++;
      $display("FAIL clken_before_edge: got %b, required 0", bus.mem_clken);
    end
    step();
    n_cmp++;
    if (bus.mem_clken !== 1'b1) begin
      n_err++;
      $display("FAIL clken_after_edge: got %b, required 1", bus.mem_clken);
    end
  endtask

  task automatic test_packing();
    bus.mem_grant = 1'b1;
    enable = 1'b1;
    step();
    bus.in_valid = 1'b1;
    bus.in_data = 16'h1234;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL pack_ready: got %b, required 1", bus.in_ready);
    end
    step();
    bus.in_data = 16'hABCD;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata} !==
        {1'b1, ADDR_W'(BASE), 4'b0011, 32'h12341234}) begin
      n_err++;
      $display("FAIL pack_write1: got wr=%b addr=%0d be=%h data=%h, required 1 %0d 3 12341234",
               bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata, BASE);
    end
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata} !==
        {1'b1, ADDR_W'(BASE), 4'b1100, 32'hABCDABCD}) begin
      n_err++;
      $display("FAIL pack_write2: got wr=%b addr=%0d be=%h data=%h, required 1 %0d c abcdabcd",
               bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata, BASE);
    end
    step();
    enable = 1'b0;
    step();
    step();
    n_cmp++;
    if ({wr_ptr, wr_half} !== {ADDR_W'(1), 1'b0}) begin
      n_err++;
      $display("FAIL pack_ptr: got ptr=%0d half=%b, required 1 0", wr_ptr, wr_half);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.mem_grant = 1'b1;
    enable = 1'b1;
    step();
    for (int i = 0; i < 8; i++) tx_q.push_back(16'h0100 + 16'(i));
    drain_tx();
    wait_idle();
    n_cmp++;
    if ({last_addr, last_be} !== {ADDR_W'(BASE + 3), 4'b1100}) begin
      n_err++;
      $display("FAIL wrap_last_write: got addr=%0d be=%h, required %0d c", last_addr, last_be, BASE + 3);
    end
    n_cmp++;
    if ({wr_ptr, wr_half, wrapped} !== {ADDR_W'(0), 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL wrap_ptr: got ptr=%0d half=%b wrapped=%b, required 0 0 1", wr_ptr, wr_half, wrapped);
    end
    tx_q.push_back(16'h0BEE);
    drain_tx();
    wait_idle();
    n_cmp++;
    if ({last_addr, last_be} !== {ADDR_W'(BASE), 4'b0011}) begin
      n_err++;
      $display("FAIL wrap_ninth: got addr=%0d be=%h, required %0d 3", last_addr, last_be, BASE);
    end
    enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] h_addr;
    logic [3:0]        h_be;
    logic [31:0]       h_data;
    int c0;
    bus.mem_grant = 1'b0;
    enable = 1'b1;
    step();
    tx_q.push_back(16'hC0DE);
    drain_tx();
    bus.in_valid = 1'b1;
    bus.in_data = 16'h5555;
    @(negedge clk);
    h_addr = bus.mem_address;
    h_be = bus.mem_byteenable;
    h_data = bus.mem_writedata;
    n_cmp++;
    if ({bus.mem_write, h_addr, h_be, h_data} !== {1'b1, ADDR_W'(BASE), 4'b1100, 32'hC0DEC0DE}) begin
      n_err++;
      $display("FAIL bp_held_write: got wr=%b addr=%0d be=%h data=%h, required 1 %0d c c0dec0de",
               bus.mem_write, h_addr, h_be, h_data, BASE);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata, bus.in_ready} !==
          {1'b1, h_addr, h_be, h_data, 1'b0}) begin
        n_err++;
        $display("FAIL bp_stable: got wr=%b addr=%0d be=%h data=%h rdy=%b, required 1 %0d %h %h 0",
                 bus.mem_write, bus.mem_address, bus.mem_byteenable, bus.mem_writedata,
                 bus.in_ready, h_addr, h_be, h_data);
      end
      step();
    end
    bus.in_valid = 1'b0;
    bus.mem_grant = 1'b1;
    c0 = wr_count;
    repeat (3) step();
    n_cmp++;
    if (wr_count - c0 != 1) begin
      n_err++;
      $display("FAIL bp_release_count: got %0d writes, required 1", wr_count - c0);
    end
    tx_q.push_back(16'h5555);
    drain_tx();
    wait_idle();
    enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_clear();
    int done = 0;
    int bad = 0;
    int n = 0;
    n_cmp++;
    if (wrapped !== 1'b1) begin
      n_err++;
      $display("FAIL clr_pre_wrapped: got %b, required 1", wrapped);
    end
    enable = 1'b0;
    bus.mem_grant = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_w.addr = ADDR_W'(BASE + i);
      exp_w.be = 4'hF;
      exp_w.data = 32'h0;
      sb_q.push_back(exp_w);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    while (n < 60 && done < DEPTH) begin
      bus.mem_grant = ~bus.mem_grant;
      @(negedge clk);
      if (busy !== 1'b1) bad++;
      if (bus.mem_write === 1'b1 && bus.mem_grant === 1'b1) done++;
      step();
      n++;
    end
    n_cmp++;
    if (done != DEPTH) begin
      n_err++;
      $display("FAIL clr_write_count: got %0d, required %0d", done, DEPTH);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL clr_busy: got %0d cycles with busy low, required 0", bad);
    end
    step();
    step();
    m_ptr = 0;
    m_half = 1'b0;
    m_wrapped = 1'b0;
    n_cmp++;
    if ({busy, wr_ptr, wr_half, wrapped, bus.in_ready} !== '0) begin
      n_err++;
      $display("FAIL clr_done: got busy=%b ptr=%0d half=%b wrapped=%b, required 0 0 0 0",
               busy, wr_ptr, wr_half, wrapped);
    end
    bus.mem_grant = 1'b1;
    enable = 1'b1;
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL clr_in_run: got busy=%b, required 0", busy);
    end
    step();
    tx_q.push_back(16'h7777);
    drain_tx();
    wait_idle();
    n_cmp++;
    if ({last_addr, last_be} !== {ADDR_W'(BASE), 4'b0011}) begin
      n_err++;
      $display("FAIL clr_run_sample: got addr=%0d be=%h, required %0d 3", last_addr, last_be, BASE);
    end
    enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_enable_drop();
    int bad = 0;
    bus.mem_grant = 1'b1;
    enable = 1'b1;
    step();
    bus.in_valid = 1'b1;
    bus.in_data = 16'h9999;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL drop_ready: got %b, required 1", bus.in_ready);
    end
    step();
    enable = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_write, bus.in_ready, busy} !== 3'b101) begin
      n_err++;
      $display("FAIL drop_pending: got wr/rdy/busy=%b%b%b, required 101", bus.mem_write, bus.in_ready, busy);
    end
    step();
    step();
    n_cmp++;
    if ({busy, bus.mem_write, wr_ptr, wr_half} !== {2'b00, ADDR_W'(1), 1'b0}) begin
      n_err++;
      $display("FAIL drop_retained: got busy=%b wr=%b ptr=%0d half=%b, required 0 0 1 0",
               busy, bus.mem_write, wr_ptr, wr_half);
    end
    enable = 1'b1;
    step();
    bus.mem_grant = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 16'h4242;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL drop2_ready: got %b, required 1", bus.in_ready);
    end
    step();
    enable = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_write !== 1'b1 || bus.in_ready !== 1'b0) bad++;
      step();
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL drop2_hold: got %0d bad cycles, required 0", bad);
    end
    bus.mem_grant = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({busy, bus.mem_write, wr_ptr, wr_half} !== {2'b00, ADDR_W'(1), 1'b1}) begin
      n_err++;
      $display("FAIL drop2_retained: got busy=%b wr=%b ptr=%0d half=%b, required 0 0 1 1",
               busy, bus.mem_write, wr_ptr, wr_half);
    end
    enable = 1'b1;
    step();
    tx_q.push_back(16'h1111);
    drain_tx();
    wait_idle();
    n_cmp++;
    if ({last_addr, last_be} !== {ADDR_W'(BASE + 1), 4'b1100}) begin
      n_err++;
      $display("FAIL drop_resume: got addr=%0d be=%h, required %0d c", last_addr, last_be, BASE + 1);
    end
    enable = 1'b0;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.mem_grant = 1'b0;
    test_reset();
    test_packing();
    test_wrap();
    test_backpressure();
    test_clear();
    test_enable_drop();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d expected writes never seen, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
